matmul_tile_mem_ctrl: RTL

MATMUL_TILE_MEM_CTRL -- requirements
Module: matmul_tile_mem_ctrl

---
 rtl/matmul_tile_mem_ctrl_pkg.sv | 19 +
 rtl/matmul_tile_mem_ctrl_ram.sv | 25 ++
 rtl/matmul_tile_mem_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_tile_mem_ctrl_pkg.sv
// Shared types and defaults for the matmul tile memory controller.
package matmul_tile_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int DEF_DWIDTH    = 16;
   localparam int DEF_AWIDTH    = 7;
   localparam int DEF_BB        = 4;
   localparam int DEF_TILE_ROWS = 2;
   localparam int DEF_TILE_COLS = 2;

endpackage

// File: rtl/matmul_tile_mem_ctrl_ram.sv
// Single-port RAM with 1-cycle synchronous read; only the read register is reset.
module single_port_ram #(
   parameter int DWIDTH = 64,
   parameter int AWIDTH = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] mem [2**AWIDTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdata <= '0;
      else          rdata <= mem[addr];
   end

endmodule

// File: rtl/matmul_tile_mem_ctrl.sv
// Tile memory controller: host-loaded A/B banks, engine-written C banks, C readout via skid buffer.
module matmul_tile_mem_ctrl
   import matmul_tile_mem_ctrl_pkg::*;
#(
   parameter int DWIDTH    = DEF_DWIDTH,
   parameter int AWIDTH    = DEF_AWIDTH,
   parameter int BB        = DEF_BB,
   parameter int TILE_ROWS = DEF_TILE_ROWS,
   parameter int TILE_COLS = DEF_TILE_COLS
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic                                     host_we,
   input  logic                                     host_sel,
   input  logic [7:0]                               host_bank,
   input  logic [AWIDTH-1:0]                        host_addr,
   input  logic [BB*DWIDTH-1:0]                     host_wdata,
   output logic                                     host_err,
   input  logic                                     start,
   input  logic [AWIDTH:0]                          drain_len,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     eng_start,
   input  logic                                     eng_done,
   input  logic [TILE_ROWS*AWIDTH-1:0]              eng_a_addr,
   output logic [TILE_ROWS*BB*DWIDTH-1:0]           eng_a_data,
   input  logic [TILE_COLS*AWIDTH-1:0]              eng_b_addr,
   output logic [TILE_COLS*BB*DWIDTH-1:0]           eng_b_data,
   input  logic [TILE_ROWS*TILE_COLS-1:0]           eng_c_we,
   input  logic [TILE_ROWS*TILE_COLS*AWIDTH-1:0]    eng_c_addr,
   input  logic [TILE_ROWS*TILE_COLS*BB*DWIDTH-1:0] eng_c_wdata,
   output logic                                     rd_valid,
   input  logic                                     rd_ready,
   output logic [BB*DWIDTH-1:0]                     rd_data,
   output logic                                     rd_last
);

   localparam int WW = BB * DWIDTH;
   localparam int NC = TILE_ROWS * TILE_COLS;
   localparam int KW = (NC > 1) ? $clog2(NC) : 1;
   localparam int LW = AWIDTH + 1;
   localparam logic [LW-1:0] DEPTH = LW'(2**AWIDTH);

   state_t            state;
   logic              bank_ok, host_wr;
   logic [LW-1:0]     len_in, len_q, len_m1;
   logic [AWIDTH-1:0] addr_cnt;
   logic [KW-1:0]     bank_cnt, infl_bank;
   logic              issue_act, issue, issue_last, infl, infl_last, pop;
   logic [1:0]        count, cnt_ap;
   logic [2:0]        occ;
   logic [WW-1:0]     buf0, buf1, push_data;
   logic              last0, last1;
   logic [WW-1:0]     c_rdata [NC];

   assign bank_ok = (host_sel == SEL_A) ? (host_bank < 8'(TILE_ROWS))
                                        : (host_bank < 8'(TILE_COLS));
   assign host_wr = host_we && (state == ST_IDLE) && bank_ok;

   for (genvar i = 0; i < TILE_ROWS; i++) begin : g_a
      logic              we;
      logic [AWIDTH-1:0] addr;
      assign we   = host_wr && (host_sel == SEL_A) && (host_bank == 8'(i));
      assign addr = (state == ST_IDLE) ? host_addr : eng_a_addr[i*AWIDTH +: AWIDTH];
      single_port_ram #(.DWIDTH(WW), .AWIDTH(AWIDTH)) u_ram (
         .clk(clk), .reset_n(reset_n), .we(we), .addr(addr),
         .wdata(host_wdata), .rdata(eng_a_data[i*WW +: WW]));
   end

   for (genvar j = 0; j < TILE_COLS; j++) begin : g_b
      logic              we;
      logic [AWIDTH-1:0] addr;
      assign we   = host_wr && (host_sel == SEL_B) && (host_bank == 8'(j));
      assign addr = (state == ST_IDLE) ? host_addr : eng_b_addr[j*AWIDTH +: AWIDTH];
      single_port_ram #(.DWIDTH(WW), .AWIDTH(AWIDTH)) u_ram (
         .clk(clk), .reset_n(reset_n), .we(we), .addr(addr),
         .wdata(host_wdata), .rdata(eng_b_data[j*WW +: WW]));
   end

   for (genvar k = 0; k < NC; k++) begin : g_c
      logic              we;
      logic [AWIDTH-1:0] addr;
      assign we   = (state == ST_RUN) && eng_c_we[k];
      assign addr = (state == ST_RUN) ? eng_c_addr[k*AWIDTH +: AWIDTH] : addr_cnt;
      single_port_ram #(.DWIDTH(WW), .AWIDTH(AWIDTH)) u_ram (
         .clk(clk), .reset_n(reset_n), .we(we), .addr(addr),
         .wdata(eng_c_wdata[k*WW +: WW]), .rdata(c_rdata[k]));
   end

   assign len_in = (drain_len > DEPTH) ? DEPTH : drain_len;
   assign len_m1 = len_q - LW'(1);

   assign rd_valid  = (count != 2'd0);
   assign rd_data   = buf0;
   assign rd_last   = rd_valid && last0;
   assign pop       = rd_valid && rd_ready;
   assign push_data = c_rdata[infl_bank];

   // Issue a read only if the word still has a skid slot once it lands, counting this cycle's pop.
   assign occ        = {1'b0, count} + {2'b0, infl} - {2'b0, pop};
   assign issue      = issue_act && (occ < 3'd2);
   assign issue_last = (bank_cnt == KW'(NC - 1)) && ({1'b0, addr_cnt} == len_m1);
   assign cnt_ap     = count - {1'b0, pop};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         eng_start <= 1'b0;
         host_err  <= 1'b0;
         len_q     <= '0;
         addr_cnt  <= '0;
         bank_cnt  <= '0;
         issue_act <= 1'b0;
         infl      <= 1'b0;
         infl_last <= 1'b0;
         infl_bank <= '0;
      end else begin
         done      <= 1'b0;
         eng_start <= 1'b0;
         host_err  <= host_we && !host_wr;
         infl      <= issue;
         infl_last <= issue_last;
         infl_bank <= bank_cnt;
         if (issue) begin
            if (issue_last) begin
               issue_act <= 1'b0;
            end else if ({1'b0, addr_cnt} == len_m1) begin
               addr_cnt <= '0;
               bank_cnt <= bank_cnt + KW'(1);
            end else begin
               addr_cnt <= addr_cnt + AWIDTH'(1);
            end
         end
         case (state)
            ST_IDLE: if (start) begin
               state     <= ST_RUN;
               busy      <= 1'b1;
               eng_start <= 1'b1;
            end
            ST_RUN: if (eng_done) begin
               len_q <= len_in;
               if (len_in == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state     <= ST_DRAIN;
                  issue_act <= 1'b1;
                  addr_cnt  <= '0;
                  bank_cnt  <= '0;
               end
            end
            ST_DRAIN: if (pop && last0) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         buf0  <= '0;
         buf1  <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
      end else begin
         if (pop && count == 2'd2) begin
            buf0  <= buf1;
            last0 <= last1;
         end
         if (infl) begin
            if (cnt_ap == 2'd0) begin
               buf0  <= push_data;
               last0 <= infl_last;
            end else begin
               buf1  <= push_data;
               last1 <= infl_last;
            end
         end
         count <= cnt_ap + {1'b0, infl};
      end
   end

endmodule
